// File: rtl/pdm_clk_gen.sv
// PDM microphone bit-clock generator with capture strobes, decimated sample
// strobe and a wake-up hold-off; glitch-free start and stop.
module pdm_clk_gen #(
  parameter int DIV_W      = 16,
  parameter int DEC_W      = 8,
  parameter int WAKE_EDGES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] half_div,
  input  logic [DEC_W-1:0] dec_ratio,
  output logic             pdm_clk,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             sample_stb,
  output logic             ready,
  output logic             running
);

  localparam int WAKE_W = $clog2(WAKE_EDGES + 1);
  localparam logic [WAKE_W-1:0] WAKE_MAX = WAKE_W'(WAKE_EDGES);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [DIV_W-1:0]   cnt, cnt_nxt, h, h_nxt, h_eff;
  logic [DEC_W-1:0]   dec_cnt, dec_nxt, d, d_nxt, d_eff;
  logic [WAKE_W-1:0]  wake_cnt, wake_nxt;
  logic               pdm_nxt, rise_nxt, fall_nxt, sample_nxt, ready_nxt, running_nxt;

  assign h_eff = (half_div == '0) ? DIV_W'(1) : half_div;
  assign d_eff = (dec_ratio == '0) ? DEC_W'(1) : dec_ratio;

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    pdm_nxt    = pdm_clk;
    cnt_nxt    = cnt;
    h_nxt      = h;
    d_nxt      = d;
    dec_nxt    = dec_cnt;
    wake_nxt   = wake_cnt;
    rise_nxt   = 1'b0;
    fall_nxt   = 1'b0;
    sample_nxt = 1'b0;
    ready_nxt  = ready;

    unique case (state)
      IDLE: begin
        if (en) begin
          state_nxt = RUN;
          h_nxt     = h_eff;
          cnt_nxt   = h_eff - 1'b1;
          d_nxt     = d_eff;
          dec_nxt   = '0;
          wake_nxt  = '0;
        end
      end
      RUN, DRAIN: begin
        // Stopping in the low phase just truncates it; a high phase always completes.
        if (state == RUN && !en && !pdm_clk) begin
          state_nxt = IDLE;
        end else begin
          if (cnt != '0) begin
            cnt_nxt = cnt - 1'b1;
          end else if (!pdm_clk) begin
            pdm_nxt   = 1'b1;
            rise_nxt  = 1'b1;
            h_nxt     = h_eff;
            cnt_nxt   = h_eff - 1'b1;
            wake_nxt  = (wake_cnt == WAKE_MAX) ? wake_cnt : wake_cnt + 1'b1;
            ready_nxt = ready | (wake_nxt == WAKE_MAX);
            if (dec_cnt >= d - 1'b1) begin
              sample_nxt = ready_nxt;
              dec_nxt    = '0;
              d_nxt      = d_eff;
            end else begin
              dec_nxt = dec_cnt + 1'b1;
            end
          end else begin
            pdm_nxt  = 1'b0;
            fall_nxt = 1'b1;
            cnt_nxt  = h - 1'b1;
          end
          state_nxt = en ? RUN : (pdm_nxt ? DRAIN : IDLE);
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt == IDLE) begin
      pdm_nxt   = 1'b0;
      ready_nxt = 1'b0;
    end
    running_nxt = (state_nxt != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, and the
  // synchronous reset overrides everything including a phase in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pdm_clk    <= 1'b0;
      cnt        <= '0;
      h          <= '0;
      d          <= '0;
      dec_cnt    <= '0;
      wake_cnt   <= '0;
      rise_stb   <= 1'b0;
      fall_stb   <= 1'b0;
      sample_stb <= 1'b0;
      ready      <= 1'b0;
      running    <= 1'b0;
    end else begin
      state      <= state_nxt;
      pdm_clk    <= pdm_nxt;
      cnt        <= cnt_nxt;
      h          <= h_nxt;
      d          <= d_nxt;
      dec_cnt    <= dec_nxt;
      wake_cnt   <= wake_nxt;
      rise_stb   <= rise_nxt;
      fall_stb   <= fall_nxt;
      sample_stb <= sample_nxt;
      ready      <= ready_nxt;
      running    <= running_nxt;
    end
  end

endmodule

// File: tb/tb_pdm_clk_gen.sv
// Directed bench for pdm_clk_gen; outputs are compared as the packed vector
// {pdm_clk, rise_stb, fall_stb, sample_stb, ready, running}.
module tb_pdm_clk_gen;

  localparam int DIV_W      = 16;
  localparam int DEC_W      = 8;
  localparam int WAKE_EDGES = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [DIV_W-1:0] half_div;
  logic [DEC_W-1:0] dec_ratio;
  logic             pdm_clk, rise_stb, fall_stb, sample_stb, ready, running;
  logic [5:0]       obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pdm_clk_gen #(
    .DIV_W(DIV_W), .DEC_W(DEC_W), .WAKE_EDGES(WAKE_EDGES)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .half_div(half_div), .dec_ratio(dec_ratio),
    .pdm_clk(pdm_clk), .rise_stb(rise_stb), .fall_stb(fall_stb),
    .sample_stb(sample_stb), .ready(ready), .running(running)
  );

  assign obs = {pdm_clk, rise_stb, fall_stb, sample_stb, ready, running};

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Half_div=3 start: rises at steps 4, 10, 16; falls at 7, 13.
  logic [5:0] exp_start [16] = '{
    6'b000001, 6'b000001, 6'b000001, 6'b110001, 6'b100001, 6'b100001,
    6'b001001, 6'b000001, 6'b000001, 6'b110001, 6'b100001, 6'b100001,
    6'b001001, 6'b000001, 6'b000001, 6'b110001
  };

  initial begin
    reset = 1'b1; en = 1'b0; half_div = 16'd3; dec_ratio = 8'd1;
    adv(2);
    check("reset_state", 6'b000000);
    reset = 1'b0;
    adv(1);
    check("idle_after_reset", 6'b000000);

    // Start with H=3, then change divisor to 5 mid high phase, then to 4.
    en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      adv(1);
      check($sformatf("start_h3_step%0d", k + 1), exp_start[k]);
    end
    adv(1);                     // step 17, high phase of the H=3 period
    half_div = 16'd5;
    adv(2);  check("div_old_fall_19", 6'b001001);
    adv(3);  check("div_rise_22", 6'b110001);
    adv(4);  check("div_high_26", 6'b100001);
    adv(1);  check("div_new_fall_27", 6'b001001);
    adv(4);  check("div_low_31", 6'b000001);
    adv(1);  check("div_rise_32", 6'b110001);
    half_div = 16'd4;
    adv(5);  check("h5_fall_37", 6'b001001);
    adv(5);  check("h4_rise_42", 6'b110001);

    // Drop en one cycle after a rise with H=4: high lasts 3 more cycles.
    en = 1'b0;
    adv(1);  check("drain_high_43", 6'b100001);
    adv(2);  check("drain_high_45", 6'b100001);
    adv(1);  check("drain_fall_46", 6'b001000);
    adv(1);  check("drain_idle_47", 6'b000000);

    // Drop en in the low phase: truncated, no strobes.
    half_div = 16'd3;
    en = 1'b1;
    adv(2);  check("low_stop_run", 6'b000001);
    en = 1'b0;
    adv(1);  check("low_stop_idle", 6'b000000);
    adv(1);  check("low_stop_stays", 6'b000000);

    // Reassert en during DRAIN: the clock continues unbroken.
    en = 1'b1;
    adv(4);  check("reassert_rise_4", 6'b110001);
    en = 1'b0;
    adv(1);  check("reassert_drain_5", 6'b100001);
    en = 1'b1;
    adv(1);  check("reassert_run_6", 6'b100001);
    adv(1);  check("reassert_fall_7", 6'b001001);
    adv(1);  check("reassert_low_8", 6'b000001);
    adv(2);  check("reassert_rise_10", 6'b110001);
    en = 1'b0;
    adv(3);  check("reassert_stop_fall", 6'b001000);
    adv(1);  check("reassert_stop_idle", 6'b000000);

    // Wake and decimation: H=2, D=4, rise k at step 4k-1.
    half_div = 16'd2;
    dec_ratio = 8'd4;
    en = 1'b1;
    adv(15); check("wake_rise4_nosample", 6'b110001);
    adv(32); check("wake_rise12_nosample", 6'b110001);
    adv(12); check("wake_rise15", 6'b110001);
    adv(4);  check("wake_rise16_ready", 6'b110111);
    adv(1);  check("wake_after16", 6'b100011);
    adv(3);  check("dec_rise17", 6'b110011);
    adv(12); check("dec_rise20", 6'b110111);
    dec_ratio = 8'd0;
    adv(12); check("dec_rise23", 6'b110011);
    adv(4);  check("dec_rise24", 6'b110111);
    adv(2);  check("dec_fall24", 6'b001011);
    adv(2);  check("dec0_rise25", 6'b110111);
    adv(2);  check("dec0_fall25", 6'b001011);
    adv(2);  check("dec0_rise26", 6'b110111);
    en = 1'b0;
    adv(2);  check("wake_stop_clears_ready", 6'b001000);

    // half_div=0 and then 1: both toggle every cycle.
    half_div = 16'd0;
    dec_ratio = 8'd1;
    en = 1'b1;
    adv(2);  check("h0_rise", 6'b110001);
    adv(1);  check("h0_fall", 6'b001001);
    adv(1);  check("h0_rise2", 6'b110001);
    half_div = 16'd1;
    adv(1);  check("h1_fall", 6'b001001);
    adv(1);  check("h1_rise", 6'b110001);
    adv(1);  check("h1_fall2", 6'b001001);
    half_div = 16'd4;
    adv(1);  check("h4_rise", 6'b110001);
    adv(1);  check("h4_high", 6'b100001);

    // Reset mid high phase, then restart from IDLE with en still high.
    reset = 1'b1;
    adv(1);  check("reset_mid_high", 6'b000000);
    reset = 1'b0;
    adv(1);  check("restart_run", 6'b000001);
    adv(3);  check("restart_low", 6'b000001);
    adv(1);  check("restart_rise", 6'b110001);
    en = 1'b0;
    adv(10); check("final_idle", 6'b000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
